bram_sdp_ctrl: RTL and testbench

Parametrised simple-dual-port block RAM with synchronous registered read, per-byte write enables, write-first read-during-write forwarding, selectable read latency and an optional post-reset clear sequencer. It is the next-generation storage primitive for the OT accelerator datapath. It replaces the unregistered-read RAM, so downstream stages get timing-clean BRAM outputs with an explicit `rd_valid` qualifier.

---
 rtl/bram_sdp_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bram_sdp_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_ctrl.sv
// Simple-dual-port block RAM with registered read, byte enables, write-first forwarding and optional post-reset clear.
// Latency: READ_LATENCY (1 or 2) cycles from an accepted rd_en edge to rd_valid/data_out; writes take effect at their edge.
// Backpressure: none; one read and one write may be accepted every cycle in RUN, requests are dropped while init_busy.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   wr_en, write_addr,       write request; wr_be bit i enables data_in byte i
//   data_in, wr_be
//   rd_en, read_addr         read request, captured at the accepting edge
//   data_out, rd_valid       read result and its qualifier; data_out holds while rd_valid is low
//   init_busy                clear sequence running, all requests ignored
module bram_sdp_ctrl #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 6,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    init_busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One bit wider than the address so the last clear address is compared
  // without any chance of wrapping back onto word 0.
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CLR_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [0:0]          state;
  logic [ADDR_WIDTH:0] clr_cnt;

  // --------------------------------------------------------------------------
  // Init / run sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      clr_cnt <= '0;
    end else if (state == ST_INIT) begin
      clr_cnt <= clr_cnt + CLR_ONE;
      if (clr_cnt == CLR_LAST) begin
        state <= ST_RUN;
      end
    end
  end

  assign init_busy = (state == ST_INIT);

  // --------------------------------------------------------------------------
  // Shared write port: clear sequencer owns it in INIT, the user in RUN.
  // Nothing is written on an edge where rst is high.
  // --------------------------------------------------------------------------
  logic [NB-1:0]         mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_acc;

  always_comb begin
    mem_we    = '0;
    mem_addr  = write_addr;
    mem_wdata = data_in;
    if (!rst) begin
      if (state == ST_INIT) begin
        mem_we    = '1;
        mem_addr  = clr_cnt[ADDR_WIDTH-1:0];
        mem_wdata = '0;
      end else if (wr_en) begin
        mem_we = wr_be;
      end
    end
  end

  assign rd_acc = !rst && (state == ST_RUN) && rd_en;

  // --------------------------------------------------------------------------
  // Storage array. The read register samples the pre-write contents; the
  // write-first behaviour is rebuilt from the bypass registers below so the
  // array itself stays a plain read-first BRAM.
  // --------------------------------------------------------------------------
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we[i]) begin
        ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (rd_acc) begin
      ram_q <= ram[read_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Read-during-write bypass, captured alongside the array read
  // --------------------------------------------------------------------------
  logic                  rd_v0;
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_dat;
  logic [NB-1:0]         byp_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v0   <= 1'b0;
      byp_hit <= 1'b0;
    end else begin
      rd_v0 <= rd_acc;
      if (rd_acc) begin
        byp_hit <= wr_en && (write_addr == read_addr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      byp_dat <= data_in;
      byp_be  <= wr_be;
    end
  end

  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    merged = ram_q;
    for (int i = 0; i < NB; i++) begin
      if (byp_hit && byp_be[i]) begin
        merged[8*i +: 8] = byp_dat[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional extra pipeline stage for READ_LATENCY = 2
  // --------------------------------------------------------------------------
  logic                  pre_v;
  logic [DATA_WIDTH-1:0] pre_dat;

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic                  mid_v;
      logic [DATA_WIDTH-1:0] mid_dat;

      always_ff @(posedge clk) begin
        if (rst) begin
          mid_v <= 1'b0;
        end else begin
          mid_v <= rd_v0;
        end
      end

      always_ff @(posedge clk) begin
        if (rd_v0) begin
          mid_dat <= merged;
        end
      end

      assign pre_v   = mid_v;
      assign pre_dat = mid_dat;
    end else begin : g_lat1
      assign pre_v   = rd_v0;
      assign pre_dat = merged;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output register: data only moves with a valid read, so it holds otherwise.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= pre_v;
      if (pre_v) begin
        data_out <= pre_dat;
      end
    end
  end

endmodule

// File: tb/tb_bram_sdp_ctrl.sv
// Testbench for bram_sdp_ctrl: two instances driven with identical stimulus.
//   dut 0: READ_LATENCY=1, CLEAR_ON_RESET=1
//   dut 1: READ_LATENCY=2, CLEAR_ON_RESET=0
module tb_bram_sdp_ctrl;

  typedef struct {
    logic [31:0] dat;
    bit          known;
    int          due;
  } exp_t;

  localparam int LAT [2] = '{1, 2};
  localparam int CLR [2] = '{1, 0};

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  wa;
  logic [3:0]  ra;
  logic [3:0]  be;
  logic [31:0] din;

  logic [31:0] dout   [2];
  logic        vld    [2];
  logic        busy_o [2];

  bram_sdp_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .write_addr(wa), .data_in(din),
    .wr_be(be), .rd_en(rd_en), .read_addr(ra), .data_out(dout[0]),
    .rd_valid(vld[0]), .init_busy(busy_o[0])
  );

  bram_sdp_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .write_addr(wa), .data_in(din),
    .wr_be(be), .rd_en(rd_en), .read_addr(ra), .data_out(dout[1]),
    .rd_valid(vld[1]), .init_busy(busy_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] mmem   [2][16];
  bit          mknown [2][16];
  bit          mbusy  [2];
  int          mclr   [2];
  logic [31:0] mlast  [2];
  bit          mlast_k[2];
  exp_t        sbq    [2][$];
  int          ecnt = 0;
  bit          started = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_edge();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        sbq[k].delete();
        mbusy[k]   = (CLR[k] != 0);
        mclr[k]    = 0;
        mlast[k]   = 32'h0;
        mlast_k[k] = 1'b1;
      end else if (mbusy[k]) begin
        mmem[k][mclr[k]]   = 32'h0;
        mknown[k][mclr[k]] = 1'b1;
        mclr[k]++;
        if (mclr[k] == 16) mbusy[k] = 1'b0;
      end else begin
        if (rd_en) begin
          e.dat   = mmem[k][ra];
          e.known = mknown[k][ra];
          if (wr_en && (wa == ra)) begin
            e.dat = merge(e.dat, din, be);
            if (be == 4'hF) e.known = 1'b1;
          end
          e.due = ecnt + LAT[k];
          sbq[k].push_back(e);
        end
        if (wr_en) begin
          mmem[k][wa] = merge(mmem[k][wa], din, be);
          if (be == 4'hF) mknown[k][wa] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d init_busy @%0d", k, ecnt), 32'(busy_o[k]), 32'(mbusy[k]));
        if (vld[k]) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("dut%0d spurious rd_valid @%0d", k, ecnt), 32'(vld[k]), 32'h0);
          end else begin
            e = sbq[k].pop_front();
            check($sformatf("dut%0d latency", k), 32'(ecnt), 32'(e.due));
            if (e.known) begin
              check($sformatf("dut%0d data @%0d", k, ecnt), dout[k], e.dat);
            end
            mlast[k]   = e.dat;
            mlast_k[k] = e.known;
          end
        end else begin
          if (sbq[k].size() > 0 && sbq[k][0].due <= ecnt) begin
            check($sformatf("dut%0d missing rd_valid @%0d", k, ecnt), 32'(vld[k]), 32'h1);
            void'(sbq[k].pop_front());
          end
          if (mlast_k[k]) begin
            check($sformatf("dut%0d data hold @%0d", k, ecnt), dout[k], mlast[k]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    ecnt++;
    model_edge();
    started = 1'b1;
    #1;
  endtask

  task automatic idle();
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wa = a; din = d; be = m;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; ra = a;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mbusy[k] = 1'b0; mclr[k] = 0; mlast[k] = 32'h0; mlast_k[k] = 1'b0;
      for (int a = 0; a < 16; a++) begin
        mmem[k][a] = 32'h0; mknown[k][a] = 1'b0;
      end
    end
    idle(); wa = 4'h0; ra = 4'h0; be = 4'h0; din = 32'h0;
    #2;

    // Clear after reset, with a read of addr 3 held throughout
    rst = 1'b1; rd(4'd3); tick();
    rst = 1'b0;
    repeat (20) tick();
    idle(); tick();

    // Byte-enable write: expect 0xAA22CC44 at addr 5
    wr(4'd5, 32'hAABBCCDD, 4'hF); tick();
    wr(4'd5, 32'h11223344, 4'h5); tick();
    idle(); rd(4'd5); tick();
    // wr_be = 0 changes nothing
    idle(); wr(4'd5, 32'hFFFFFFFF, 4'h0); tick();
    idle(); rd(4'd5); tick();

    // Write-first forwarding: expect 0xDEAD5678
    idle(); wr(4'd7, 32'hDEADBEEF, 4'hF); tick();
    wr(4'd7, 32'h12345678, 4'h3); rd(4'd7); tick();
    // Different addresses on one edge, then read-after-write next cycle
    wr(4'd8, 32'h0BADF00D, 4'hF); rd(4'd5); tick();
    idle(); rd(4'd8); tick();
    idle(); repeat (3) tick();

    // Streaming: fill then back-to-back reads
    for (int a = 0; a < 16; a++) begin
      idle(); wr(4'(a), 32'(a) * 32'h01010101, 4'hF); tick();
    end
    for (int a = 0; a < 16; a++) begin
      idle(); rd(4'(a)); tick();
    end
    idle(); repeat (4) tick();

    // Random mix of reads, writes and collisions
    for (int n = 0; n < 300; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) wr(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 2) == 0) rd(wa);
        else rd(4'($urandom_range(0, 15)));
      end
      tick();
    end
    idle(); repeat (4) tick();

    // Reset mid-read and retention across reset
    wr(4'd15, 32'hCAFEF00D, 4'hF); tick();
    idle(); rd(4'd15); tick();
    rst = 1'b1; rd(4'd15); wr(4'd15, 32'h00000000, 4'hF); tick();
    idle(); rd(4'd15); tick();
    idle(); repeat (4) tick();
    repeat (14) tick();
    rd(4'd15); tick();
    idle(); repeat (5) tick();

    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d drained", k), 32'(sbq[k].size()), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
